// File: rtl/fifo_rd_pkg.sv
// Shared types and sizing for the sync_fifo read-side stream adapter.
package fifo_rd_pkg;

  localparam int unsigned SKID_DEPTH = 2;

  typedef logic [1:0] occ_t;
  typedef logic       ptr_t;

endpackage

// File: rtl/fifo_stream_reader_skid_buf2.sv
// Two-entry register FIFO that absorbs the sync_fifo read latency.
module skid_buf2
  import fifo_rd_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] head_data_o,
  output occ_t                  occ_o
);

  logic [DATA_WIDTH-1:0] mem_q [SKID_DEPTH];
  ptr_t                  head_q, head_d;
  ptr_t                  tail_q, tail_d;
  occ_t                  occ_q,  occ_d;

  // One-bit pointers wrap at 2 by simple inversion.
  always_comb begin
    head_d = pop_i  ? ~head_q : head_q;
    tail_d = push_i ? ~tail_q : tail_q;
    occ_d  = occ_q + occ_t'(push_i) - occ_t'(pop_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SKID_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[tail_q] <= push_data_i;
      end
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  assign head_data_o = mem_q[head_q];
  assign occ_o       = occ_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a sync_fifo read port into a valid/ready stream at full rate.
module fifo_stream_reader
  import fifo_rd_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  beat_count
);

  occ_t                 occ;
  logic                 inflight_q, inflight_d;
  logic [CNT_WIDTH-1:0] beat_count_q, beat_count_d;
  logic                 pop;
  logic [2:0]           pending;

  skid_buf2 #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (inflight_q),
    .push_data_i (fifo_rd_data),
    .pop_i       (pop),
    .head_data_o (m_data),
    .occ_o       (occ)
  );

  assign m_valid = (occ != '0);

  // A pop in this cycle frees a slot in time for a read issued now,
  // hence the only combinational path: m_ready -> fifo_rd_en.
  always_comb begin
    pop          = m_valid && m_ready;
    pending      = {1'b0, occ} + {2'b0, inflight_q};
    fifo_rd_en   = rst_n && !fifo_empty && ((pending < 3'(SKID_DEPTH)) || pop);
    inflight_d   = fifo_rd_en;
    beat_count_d = beat_count_q + CNT_WIDTH'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q   <= 1'b0;
      beat_count_q <= '0;
    end else begin
      inflight_q   <= inflight_d;
      beat_count_q <= beat_count_d;
    end
  end

  assign beat_count = beat_count_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader against a behavioural sync_fifo read port.
module tb_fifo_stream_reader;

  localparam int DW = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          frst_n = 1'b0;
  logic          fifo_empty;
  logic [DW-1:0] fifo_rd_data;
  logic          fifo_rd_en;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready = 1'b0;
  logic [CW-1:0] beat_count;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] q[$];
  logic [7:0] wq[$];
  logic [7:0] got[$];
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  fifo_stream_reader #(
    .DATA_WIDTH (DW),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fifo_empty   (fifo_empty),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_en   (fifo_rd_en),
    .m_valid      (m_valid),
    .m_data       (m_data),
    .m_ready      (m_ready),
    .beat_count   (beat_count)
  );

  // sync_fifo read port: registered rd_data, writes visible after the next edge.
  always @(posedge clk or negedge frst_n) begin
    if (!frst_n) begin
      q.delete();
      wq.delete();
      fifo_empty   <= 1'b1;
      fifo_rd_data <= '0;
    end else begin
      if (fifo_rd_en && q.size() != 0) fifo_rd_data <= q.pop_front();
      while (wq.size() != 0) q.push_back(wq.pop_front());
      fifo_empty <= (q.size() == 0);
    end
  end

  always @(negedge clk) begin
    if (rst_n && frst_n) begin
      n_assert++;
      if (dut.occ > 2'd2) begin
        n_fail++;
        $display("FAIL occ_bound: got %0d expected <= 2", dut.occ);
      end
      n_assert++;
      if (fifo_rd_en && fifo_empty) begin
        n_fail++;
        $display("FAIL rd_en_while_empty: got rd_en=1 expected 0 at t=%0t", $time);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic cycle(input logic rdy);
    @(posedge clk);
    #1;
    m_ready = rdy;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    frst_n = 1'b0;
    m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    frst_n = 1'b1;
    got.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    frst_n = 1'b1;
    m_ready = 1'b0;
    got.delete();
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      logic [7:0] b;
      b = 8'h10 + 8'(i);
      wq.push_back(b);
      exp_q.push_back(b);
    end
    @(posedge clk);
    #2;
    for (int c = 0; c < 3; c++) begin
      n_assert++;
      if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL rst_rd_en: got %b expected 0", fifo_rd_en); end
      n_assert++;
      if (m_valid !== 1'b0) begin n_fail++; $display("FAIL rst_m_valid: got %b expected 0", m_valid); end
      n_assert++;
      if (m_data !== 8'h00) begin n_fail++; $display("FAIL rst_m_data: got %h expected 00", m_data); end
      n_assert++;
      if (beat_count !== 16'd0) begin n_fail++; $display("FAIL rst_beat_count: got %0d expected 0", beat_count); end
      @(posedge clk);
      #2;
    end
    rst_n = 1'b1;
    #1;
    n_assert++;
    if (fifo_rd_en !== 1'b1) begin n_fail++; $display("FAIL rst_release_rd_en: got %b expected 1", fifo_rd_en); end
    m_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      cycle(1'b1);
      if (m_valid && m_ready) got.push_back(m_data);
    end
    n_assert++;
    if (got.size() != 4) begin n_fail++; $display("FAIL rst_drain_count: got %0d expected 4", got.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_assert++;
      if (i >= got.size() || got[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL rst_drain_data[%0d]: got %h expected %h", i, (i < got.size()) ? got[i] : 8'hxx, exp_q[i]);
      end
    end
  endtask

  task automatic test_full_rate();
    int first_rd = -1;
    int first_v  = -1;
    int first_b  = -1;
    int last_b   = -1;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      wq.push_back(b);
      exp_q.push_back(b);
    end
    for (int c = 0; c < 20; c++) begin
      cycle(1'b1);
      if (fifo_rd_en && first_rd < 0) first_rd = c;
      if (m_valid && first_v < 0) first_v = c;
      if (m_valid && m_ready) begin
        got.push_back(m_data);
        if (first_b < 0) first_b = c;
        last_b = c;
      end
    end
    // rd_en sampled at edge k, data captured at edge k+1, valid visible after it.
    n_assert++;
    if (first_rd < 0 || first_v != first_rd + 2) begin
      n_fail++;
      $display("FAIL full_first_valid: got cycle %0d expected %0d", first_v, first_rd + 2);
    end
    n_assert++;
    if (last_b - first_b != 9) begin
      n_fail++;
      $display("FAIL full_consecutive: got span %0d expected 9", last_b - first_b);
    end
    n_assert++;
    if (got.size() != 10) begin n_fail++; $display("FAIL full_count: got %0d expected 10", got.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_assert++;
      if (i >= got.size() || got[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL full_data[%0d]: got %h expected %h", i, (i < got.size()) ? got[i] : 8'hxx, exp_q[i]);
      end
    end
    n_assert++;
    if (beat_count !== 16'd10) begin n_fail++; $display("FAIL full_beat_count: got %0d expected 10", beat_count); end
    n_assert++;
    if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL full_rd_en_idle: got %b expected 0", fifo_rd_en); end
  endtask

  task automatic test_backpressure();
    logic seen = 1'b0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      logic [7:0] b;
      b = 8'h30 + 8'(i * 7);
      wq.push_back(b);
      exp_q.push_back(b);
    end
    for (int c = 0; c < 10 && !seen; c++) begin
      cycle(1'b0);
      if (m_valid) seen = 1'b1;
    end
    n_assert++;
    if (!seen) begin n_fail++; $display("FAIL bp_valid_timeout: got m_valid=0 expected 1"); end
    for (int h = 0; h < 6; h++) begin
      n_assert++;
      if (m_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid[%0d]: got %b expected 1", h, m_valid); end
      n_assert++;
      if (m_data !== exp_q[0]) begin n_fail++; $display("FAIL bp_hold_data[%0d]: got %h expected %h", h, m_data, exp_q[0]); end
      n_assert++;
      if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL bp_rd_en[%0d]: got %b expected 0", h, fifo_rd_en); end
      if (h < 5) cycle(1'b0);
    end
    n_assert++;
    if (dut.occ !== 2'd2) begin n_fail++; $display("FAIL bp_occ_full: got %0d expected 2", dut.occ); end
    m_ready = 1'b1;
    #1;
    for (int c = 0; c < 25; c++) begin
      if (m_valid && m_ready) got.push_back(m_data);
      cycle(1'b1);
    end
    n_assert++;
    if (got.size() != 10) begin n_fail++; $display("FAIL bp_count: got %0d expected 10", got.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_assert++;
      if (i >= got.size() || got[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL bp_data[%0d]: got %h expected %h", i, (i < got.size()) ? got[i] : 8'hxx, exp_q[i]);
      end
    end
    n_assert++;
    if (beat_count !== 16'd10) begin n_fail++; $display("FAIL bp_beat_count: got %0d expected 10", beat_count); end
  endtask

  task automatic test_toggle_ready();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      logic [7:0] b;
      b = 8'hC0 ^ 8'(i * 13);
      wq.push_back(b);
      exp_q.push_back(b);
    end
    for (int c = 0; c < 40; c++) begin
      cycle(c % 2 == 0);
      if (m_valid && m_ready) got.push_back(m_data);
    end
    n_assert++;
    if (got.size() != 10) begin n_fail++; $display("FAIL tog_count: got %0d expected 10", got.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_assert++;
      if (i >= got.size() || got[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL tog_data[%0d]: got %h expected %h", i, (i < got.size()) ? got[i] : 8'hxx, exp_q[i]);
      end
    end
    n_assert++;
    if (beat_count !== 16'd10) begin n_fail++; $display("FAIL tog_beat_count: got %0d expected 10", beat_count); end
  endtask

  task automatic test_underflow_gap();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      logic [7:0] b;
      b = 8'h51 + 8'(i);
      wq.push_back(b);
      exp_q.push_back(b);
    end
    for (int c = 0; c < 12; c++) begin
      cycle(1'b1);
      if (m_valid && m_ready) got.push_back(m_data);
    end
    n_assert++;
    if (got.size() != 3) begin n_fail++; $display("FAIL gap_first_burst: got %0d expected 3", got.size()); end
    for (int g = 0; g < 4; g++) begin
      n_assert++;
      if (m_valid !== 1'b0) begin n_fail++; $display("FAIL gap_idle_valid[%0d]: got %b expected 0", g, m_valid); end
      cycle(1'b1);
    end
    for (int i = 0; i < 2; i++) begin
      logic [7:0] b;
      b = 8'h91 + 8'(i);
      wq.push_back(b);
      exp_q.push_back(b);
    end
    for (int c = 0; c < 10; c++) begin
      cycle(1'b1);
      if (m_valid && m_ready) got.push_back(m_data);
    end
    n_assert++;
    if (got.size() != 5) begin n_fail++; $display("FAIL gap_total: got %0d expected 5", got.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_assert++;
      if (i >= got.size() || got[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL gap_data[%0d]: got %h expected %h", i, (i < got.size()) ? got[i] : 8'hxx, exp_q[i]);
      end
    end
    n_assert++;
    if (beat_count !== 16'd5) begin n_fail++; $display("FAIL gap_beat_count: got %0d expected 5", beat_count); end
  endtask

  task automatic test_midstream_reset();
    logic reached = 1'b0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      logic [7:0] b;
      b = 8'hA0 + 8'(i);
      wq.push_back(b);
    end
    for (int c = 0; c < 30 && !reached; c++) begin
      cycle(got.size() < 3);
      if (m_valid && m_ready) got.push_back(m_data);
      if (got.size() == 3 && !m_ready && dut.occ == 2'd2) reached = 1'b1;
    end
    n_assert++;
    if (!reached) begin n_fail++; $display("FAIL mr_occ2_timeout: got occ=%0d expected 2", dut.occ); end
    n_assert++;
    if (beat_count !== 16'd3) begin n_fail++; $display("FAIL mr_pre_count: got %0d expected 3", beat_count); end
    rst_n = 1'b0;
    frst_n = 1'b0;
    #1;
    n_assert++;
    if (m_valid !== 1'b0) begin n_fail++; $display("FAIL mr_async_valid: got %b expected 0", m_valid); end
    n_assert++;
    if (m_data !== 8'h00) begin n_fail++; $display("FAIL mr_async_data: got %h expected 00", m_data); end
    n_assert++;
    if (beat_count !== 16'd0) begin n_fail++; $display("FAIL mr_async_count: got %0d expected 0", beat_count); end
    n_assert++;
    if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL mr_async_rd_en: got %b expected 0", fifo_rd_en); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    frst_n = 1'b1;
    got.delete();
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      logic [7:0] b;
      b = 8'hE1 + 8'(i * 3);
      wq.push_back(b);
      exp_q.push_back(b);
    end
    for (int c = 0; c < 15; c++) begin
      cycle(1'b1);
      if (m_valid && m_ready) got.push_back(m_data);
    end
    n_assert++;
    if (got.size() != 4) begin n_fail++; $display("FAIL mr_post_count: got %0d expected 4", got.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_assert++;
      if (i >= got.size() || got[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL mr_post_data[%0d]: got %h expected %h", i, (i < got.size()) ? got[i] : 8'hxx, exp_q[i]);
      end
    end
    n_assert++;
    if (beat_count !== 16'd4) begin n_fail++; $display("FAIL mr_post_beat_count: got %0d expected 4", beat_count); end
  endtask

  initial begin
    test_reset();
    test_full_rate();
    test_backpressure();
    test_toggle_ready();
    test_underflow_gap();
    test_midstream_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
